// File: rtl/pipe_hold_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_hold_ctrl_pkg                                     |
// | Description : Shared types and constants for the pipeline hold/flush |
// |               controller.                                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pipe_hold_ctrl_pkg;

    // Controller states: normal flow, one-cycle load-use bubble, memory wait
    typedef enum logic [1:0] {
        HOLD_RUN   = 2'd0,
        HOLD_STALL = 2'd1,
        HOLD_WAIT  = 2'd2
    } hold_state_t;

    // addi x0,x0,0 - loaded into IF/ID on flush and reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : pipe_hold_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hold_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_hold_ctrl_if                                      |
// | Description : Hazard/fetch inputs and hold/flush outputs of the      |
// |               pipeline hold controller.                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface pipe_hold_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_stall;
    logic             branch_taken_EX;
    logic             mem_busy;
    logic [31:0]      inst_data_IF;
    logic [31:0]      pc_IF;
    logic             pc_write_en;
    logic             bubble_EX;
    logic             freeze;
    logic [31:0]      inst_data_ID;
    logic [31:0]      pc_ID;
    logic             valid_ID;
    logic [CNT_W-1:0] stall_cycles;

    // Surrounding pipeline: drives hazards and fetch data, observes controls
    modport master (
        output load_use_stall, branch_taken_EX, mem_busy, inst_data_IF, pc_IF,
        input  pc_write_en, bubble_EX, freeze, inst_data_ID, pc_ID, valid_ID,
               stall_cycles
    );

    // Hold controller itself
    modport slave (
        input  load_use_stall, branch_taken_EX, mem_busy, inst_data_IF, pc_IF,
        output pc_write_en, bubble_EX, freeze, inst_data_ID, pc_ID, valid_ID,
               stall_cycles
    );

endinterface : pipe_hold_ctrl_if
`default_nettype wire

// File: rtl/pipe_hold_ctrl_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_hold_ctrl_if_id_reg                               |
// | Description : IF/ID pipeline register (instruction, PC, valid) with  |
// |               load enable and NOP flush.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pipe_hold_ctrl_if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipe_hold_ctrl_pkg::NOP_INSTR,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        we,
    input  wire logic        flush,
    input  wire logic [31:0] inst_in,
    input  wire logic [31:0] pc_in,
    output logic      [31:0] inst_out,
    output logic      [31:0] pc_out,
    output logic             valid_out
);

    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic        r_valid;

    // Reset to NOP; flush loads a NOP tagged with the incoming PC; else load on we
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inst  <= NOP_INSTR;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_inst  <= NOP_INSTR;
            r_pc    <= pc_in;
            r_valid <= 1'b0;
        end else if (we) begin
            r_inst  <= inst_in;
            r_pc    <= pc_in;
            r_valid <= 1'b1;
        end
    end

    assign inst_out  = r_inst;
    assign pc_out    = r_pc;
    assign valid_out = r_valid;

endmodule : pipe_hold_ctrl_if_id_reg
`default_nettype wire

// File: rtl/pipe_hold_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pipe_hold_ctrl                                         |
// | Description : Turns load-use stall, EX branch redirect and data-     |
// |               memory wait into PC enable, IF/ID hold/flush, ID/EX    |
// |               bubble and pipe freeze; owns the IF/ID register.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pipe_hold_ctrl #(
    parameter logic [31:0] NOP_INSTR = pipe_hold_ctrl_pkg::NOP_INSTR,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 16   // must match the interface CNT_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pipe_hold_ctrl_if.slave bus
);
    import pipe_hold_ctrl_pkg::hold_state_t;
    import pipe_hold_ctrl_pkg::HOLD_RUN;
    import pipe_hold_ctrl_pkg::HOLD_STALL;
    import pipe_hold_ctrl_pkg::HOLD_WAIT;

    hold_state_t      r_state;
    hold_state_t      w_next_state;
    logic             w_pc_write_en;
    logic             w_bubble_EX;
    logic             w_freeze;
    logic             w_ifid_we;
    logic             w_ifid_flush;
    logic [CNT_W-1:0] r_stall_cycles;

    // State register; reset returns to RUN even mid-stall or mid-wait
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= HOLD_RUN;
        else        r_state <= w_next_state;
    end

    // Control decode: mem_busy > branch_taken_EX > load_use_stall.
    // WAIT with mem_busy low behaves as RUN, so mem_busy is decoded the same
    // way in every state; only STALL differs, by ignoring a spurious
    // load_use_stall (the load has already moved on to MEM).
    always_comb begin
        w_next_state  = HOLD_RUN;
        w_pc_write_en = 1'b1;
        w_bubble_EX   = 1'b0;
        w_freeze      = 1'b0;
        w_ifid_we     = 1'b1;
        w_ifid_flush  = 1'b0;
        if (!rst_n) begin
            w_bubble_EX = 1'b1;
        end else if (bus.mem_busy) begin
            w_pc_write_en = 1'b0;
            w_ifid_we     = 1'b0;
            w_freeze      = 1'b1;
            w_next_state  = HOLD_WAIT;
        end else if (bus.branch_taken_EX) begin
            w_ifid_flush  = 1'b1;
            w_bubble_EX   = 1'b1;
        end else if (bus.load_use_stall && (r_state != HOLD_STALL)) begin
            w_pc_write_en = 1'b0;
            w_ifid_we     = 1'b0;
            w_bubble_EX   = 1'b1;
            w_next_state  = HOLD_STALL;
        end
    end

    // Saturating count of cycles where the PC did not advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!w_pc_write_en && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    pipe_hold_ctrl_if_id_reg #(
        .NOP_INSTR (NOP_INSTR),
        .RESET_PC  (RESET_PC)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (w_ifid_we),
        .flush     (w_ifid_flush),
        .inst_in   (bus.inst_data_IF),
        .pc_in     (bus.pc_IF),
        .inst_out  (bus.inst_data_ID),
        .pc_out    (bus.pc_ID),
        .valid_out (bus.valid_ID)
    );

    assign bus.pc_write_en  = w_pc_write_en;
    assign bus.bubble_EX    = w_bubble_EX;
    assign bus.freeze       = w_freeze;
    assign bus.stall_cycles = r_stall_cycles;

endmodule : pipe_hold_ctrl
`default_nettype wire
